// File: rtl/sd_1011_ndm.sv
// sd_1011_ndm: serial detector for the bit pattern 1-0-1-1.
// Matches do not overlap, and the output is Mealy-style.
//
// One bit of PI is consumed on each rising edge of clk. PO is high while the
// fourth bit of a match is on PI. PO is combinational from the state and PI,
// so downstream logic must sample it on the rising edge of clk.
//
// After a match, detection starts again from idle. No bit of a completed
// match counts toward the next one.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high; returns the FSM to idle
//   PI     in   serial data bit
//   PO     out  match indicator (combinational)
module sd_1011_ndm (
  input  logic clk,
  input  logic reset,
  input  logic PI,
  output logic PO
);

  // Each state records how much of the pattern has been seen so far.
  typedef enum logic [1:0] {
    S0 = 2'b00,  // nothing matched
    S1 = 2'b01,  // "1"
    S2 = 2'b10,  // "10"
    S3 = 2'b11   // "101"
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // A non-0/1 value on PI falls through to the default arm, so the next state
  // resolves to idle.
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0: begin
        case (PI)
          1'b1:    state_d = S1;
          default: state_d = S0;
        endcase
      end
      S1: begin
        case (PI)
          1'b1:    state_d = S1;
          1'b0:    state_d = S2;
          default: state_d = S0;
        endcase
      end
      S2: begin
        case (PI)
          1'b1:    state_d = S3;
          default: state_d = S0;
        endcase
      end
      S3: begin
        // On a 1 the match is consumed and detection restarts from idle.
        // On a 0 the input so far reads "1010", whose trailing "10" is kept.
        case (PI)
          1'b0:    state_d = S2;
          default: state_d = S0;
        endcase
      end
      default: state_d = S0;
    endcase
  end

  always_comb begin
    PO = 1'b0;
    if (state_q == S3) begin
      PO = PI;
    end
  end

endmodule

// File: tb/tb_sd_1011_ndm.sv
// Testbench for sd_1011_ndm. It uses directed streams, an asynchronous reset
// case, and a long random stream.
//
// The reference model keeps the bits seen since the last match or reset. A
// match is declared when those bits end in "1011"; the bits are then cleared.
module tb_sd_1011_ndm;

  logic clk;
  logic reset;
  logic PI;
  logic PO;

  int n_checks = 0;
  int n_pass   = 0;
  int hits     = 0;

  // Bits received since the last restart. Only the last three bits matter,
  // so the queue is trimmed to that length.
  logic hist[$];

  sd_1011_ndm dut (
    .clk   (clk),
    .reset (reset),
    .PI    (PI),
    .PO    (PO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_po(input logic b);
    int n;
    n = hist.size();
    if (reset) return 1'b0;
    if (b !== 1'b1 || n < 3) return 1'b0;
    return (hist[n-3] === 1'b1) && (hist[n-2] === 1'b0) && (hist[n-1] === 1'b1);
  endfunction

  task automatic model_edge(input logic b);
    if (reset) begin
      hist.delete();
    end else if (model_po(b)) begin
      hist.delete();
    end else begin
      hist.push_back(b);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: PO=%b expected %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one bit in the low phase and check PO before the edge. After the
  // edge, check PO again against the new state with PI unchanged.
  task automatic step(input logic b, input string tag);
    @(negedge clk);
    PI = b;
    #1;
    chk(tag, PO, model_po(b));
    if (PO === 1'b1) hits++;
    @(posedge clk);
    model_edge(b);
    #1;
    chk({tag, "_post"}, PO, model_po(b));
  endtask

  task automatic sync_reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    PI    = 1'b0;
    @(posedge clk);
    model_edge(1'b0);
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
  endtask

  initial begin
    logic [7:0] s2;
    logic [7:0] s3;
    logic [5:0] s4;
    logic [5:0] s5;
    logic b;

    // Test 1: reset held with PI toggling; PO must stay low.
    reset = 1'b1;
    PI    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2 PI = ~PI;
      #2 chk("reset_hold", PO, 1'b0);
      #1;
    end
    reset = 1'b0;
    PI    = 1'b0;
    hist.delete();
    #1 chk("reset_release", PO, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, "idle_zero");

    // Test 2: 1,0,1,1,0,1,1,0 gives one match. The overlapping second "1011"
    // must not fire.
    s2 = 8'b1011_0110;
    hits = 0;
    for (int i = 7; i >= 0; i--) step(s2[i], "stream_nonoverlap");
    chk_int("stream_nonoverlap_hits", hits, 1);

    // Test 3: 1,0,1,1,1,0,1,1 gives two matches.
    sync_reset_pulse();
    s3 = 8'b1011_1011;
    hits = 0;
    for (int i = 7; i >= 0; i--) step(s3[i], "stream_two");
    chk_int("stream_two_hits", hits, 2);

    // Test 4: 1,0,1,0,1,1 exercises the S3-on-0 path.
    sync_reset_pulse();
    s4 = 6'b101011;
    hits = 0;
    for (int i = 5; i >= 0; i--) step(s4[i], "stream_s3_zero");
    chk_int("stream_s3_zero_hits", hits, 1);

    // Test 5: 1,1,1,0,1,1 exercises the S1 self-loop.
    sync_reset_pulse();
    s5 = 6'b111011;
    hits = 0;
    for (int i = 5; i >= 0; i--) step(s5[i], "stream_s1_loop");
    chk_int("stream_s1_loop_hits", hits, 1);

    // Test 6: asynchronous reset while in S3 with PI=1.
    sync_reset_pulse();
    step(1'b1, "pre_async");
    step(1'b0, "pre_async");
    step(1'b1, "pre_async");
    @(negedge clk);
    PI = 1'b1;
    #1 chk("async_before", PO, 1'b1);
    #1 reset = 1'b1;
    #1 chk("async_drop", PO, 1'b0);
    @(posedge clk);
    model_edge(1'b1);
    #1 chk("async_held", PO, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    PI    = 1'b0;
    hist.delete();
    #1 chk("async_release", PO, 1'b0);
    hits = 0;
    step(1'b1, "post_async");
    step(1'b1, "post_async");
    step(1'b0, "post_async");
    step(1'b1, "post_async");
    step(1'b1, "post_async");
    chk_int("post_async_hits", hits, 1);

    // Random stream, 1-biased, with occasional asynchronous resets mid-cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("rand_async", PO, 1'b0);
        @(posedge clk);
        model_edge(PI);
        #1 reset = 1'b0;
        hist.delete();
      end
      b = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      step(b, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
